// File: rtl/vbus_pkg.sv
// vbus_pkg: shared definitions for the GPU video-port bus initiator.
//   - vbus_state_e : initiator sequencing states
//   - VRAM/OAM address window bounds
//   - GPU mode encodings (mode_video)
//   - in_window()  : inclusive address range test
package vbus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GATE   = 3'd1,
        ST_SETUP  = 3'd2,
        ST_STROBE = 3'd3,
        ST_RESP   = 3'd4
    } vbus_state_e;

    localparam logic [15:0] VRAM_LO = 16'h8000;
    localparam logic [15:0] VRAM_HI = 16'h9FFF;
    localparam logic [15:0] OAM_LO  = 16'hFE00;
    localparam logic [15:0] OAM_HI  = 16'hFE9F;

    localparam logic [1:0] MODE_HBLANK = 2'd0;
    localparam logic [1:0] MODE_VBLANK = 2'd1;
    localparam logic [1:0] MODE_OAM    = 2'd2;
    localparam logic [1:0] MODE_XFER   = 2'd3;

    function automatic logic in_window(input logic [15:0] addr,
                                       input logic [15:0] lo,
                                       input logic [15:0] hi);
        return (addr >= lo) && (addr <= hi);
    endfunction

endpackage

// File: rtl/vbus_gate_check.sv
// vbus_gate_check: combinational access-window check for the GPU video port.
//   addr_i    in  16  target address
//   mode_i    in  2   GPU mode
//   blocked_o out 1   1 = access not permitted in this mode
// VRAM is closed during pixel transfer; OAM is closed during OAM scan and
// transfer. Every other address is always open.
module vbus_gate_check
    import vbus_pkg::*;
(
    input  logic [15:0] addr_i,
    input  logic [1:0]  mode_i,
    output logic        blocked_o
);

    // Window/mode decode.
    always_comb begin
        blocked_o = 1'b0;
        if (in_window(addr_i, VRAM_LO, VRAM_HI) && (mode_i == MODE_XFER)) begin
            blocked_o = 1'b1;
        end else if (in_window(addr_i, OAM_LO, OAM_HI) && (mode_i >= MODE_OAM)) begin
            blocked_o = 1'b1;
        end else begin
            blocked_o = 1'b0;
        end
    end

endmodule

// File: rtl/vbus_initiator.sv
// vbus_initiator: single-command bus master for the GPU video port.
// Accepts one read/write over cmd_valid/cmd_ready, waits for the mode window
// to open, then runs setup/strobe phases paced by cpu_ce and returns a
// one-clock response pulse.
// Ports:
//   clk33, top_rst_b (async active-low), cpu_ce (timing tick)
//   cmd_valid/cmd_ready/cmd_we/cmd_addr/cmd_wdata : command channel
//   rsp_valid/rsp_rdata/rsp_err                   : response channel
//   mode_video, do_video                          : from GPU
//   mem_enable_video, rd_n_video, wr_n_video, A_video, di_video : to GPU
// Optional feature macro: VBUS_TIMEOUT_EN -- aborts a command that stays
// mode-blocked for TIMEOUT_TICKS ticks (rsp_err=1, rsp_rdata=8'hFF).
module vbus_initiator
    import vbus_pkg::*;
#(
    parameter int SETUP_TICKS   = 1,
    parameter int STROBE_TICKS  = 2,
    parameter int TIMEOUT_TICKS = 1024
) (
    input  logic        clk33,
    input  logic        top_rst_b,
    input  logic        cpu_ce,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [15:0] cmd_addr,
    input  logic [7:0]  cmd_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_err,
    input  logic [1:0]  mode_video,
    input  logic [7:0]  do_video,
    output logic        mem_enable_video,
    output logic        rd_n_video,
    output logic        wr_n_video,
    output logic [15:0] A_video,
    output logic [7:0]  di_video
);

    localparam logic [3:0] SETUP_LAST  = 4'(SETUP_TICKS);
    localparam logic [3:0] STROBE_LAST = 4'(STROBE_TICKS);

    vbus_state_e state_q;
    logic        we_q;
    logic [15:0] addr_q;
    logic [7:0]  wdata_q;
    logic [3:0]  tick_q;
    logic [3:0]  tick_d;
    logic        cmd_ready_q;
    logic        rsp_valid_q;
    logic [7:0]  rsp_rdata_q;
    logic        mem_en_q;
    logic        rd_n_q;
    logic        wr_n_q;
    logic [15:0] a_q;
    logic [7:0]  di_q;
    logic        blocked_s;

    vbus_gate_check u_gate (
        .addr_i    (addr_q),
        .mode_i    (mode_video),
        .blocked_o (blocked_s)
    );

    // Saturating phase tick counter increment.
    assign tick_d = (tick_q == 4'hF) ? tick_q : (tick_q + 4'd1);

`ifdef VBUS_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_TICKS);
    logic [15:0] to_q;
    logic [15:0] to_d;
    logic        rsp_err_q;

    // Saturating blocked-wait counter increment.
    assign to_d    = (to_q == 16'hFFFF) ? to_q : (to_q + 16'd1);
    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

    // Command sequencing FSM with registered port outputs.
    always_ff @(posedge clk33 or negedge top_rst_b) begin
        if (!top_rst_b) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            addr_q      <= 16'h0000;
            wdata_q     <= 8'h00;
            tick_q      <= 4'd0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 8'h00;
            mem_en_q    <= 1'b0;
            rd_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
            a_q         <= 16'h0000;
            di_q        <= 8'h00;
`ifdef VBUS_TIMEOUT_EN
            to_q        <= 16'd0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            // Response is a single-cycle pulse unless re-set below.
            rsp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready_q) begin
                        we_q        <= cmd_we;
                        addr_q      <= cmd_addr;
                        wdata_q     <= cmd_wdata;
                        cmd_ready_q <= 1'b0;
                        state_q     <= ST_GATE;
`ifdef VBUS_TIMEOUT_EN
                        to_q        <= 16'd0;
`endif
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                ST_GATE: begin
                    if (cpu_ce && !blocked_s) begin
                        a_q      <= addr_q;
                        di_q     <= wdata_q;
                        mem_en_q <= 1'b1;
                        tick_q   <= 4'd0;
                        state_q  <= ST_SETUP;
                    end else if (cpu_ce) begin
`ifdef VBUS_TIMEOUT_EN
                        // Blocked tick: abort without ever touching the bus.
                        to_q <= to_d;
                        if (to_d >= TIMEOUT_LAST) begin
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= 8'hFF;
                            state_q     <= ST_RESP;
                        end else begin
                            state_q <= ST_GATE;
                        end
`else
                        state_q <= ST_GATE;
`endif
                    end else begin
                        state_q <= ST_GATE;
                    end
                end
                ST_SETUP: begin
                    if (cpu_ce && (tick_d >= SETUP_LAST)) begin
                        // Exactly one strobe goes low, selected by direction.
                        tick_q  <= 4'd0;
                        rd_n_q  <= we_q;
                        wr_n_q  <= ~we_q;
                        state_q <= ST_STROBE;
                    end else if (cpu_ce) begin
                        tick_q <= tick_d;
                    end else begin
                        tick_q <= tick_q;
                    end
                end
                ST_STROBE: begin
                    if (cpu_ce && (tick_d >= STROBE_LAST)) begin
                        // Final tick: sample read data and close the cycle.
                        rd_n_q      <= 1'b1;
                        wr_n_q      <= 1'b1;
                        mem_en_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        if (!we_q) begin
                            rsp_rdata_q <= do_video;
                        end else begin
                            rsp_rdata_q <= rsp_rdata_q;
                        end
`ifdef VBUS_TIMEOUT_EN
                        rsp_err_q   <= 1'b0;
`endif
                        state_q     <= ST_RESP;
                    end else if (cpu_ce) begin
                        tick_q <= tick_d;
                    end else begin
                        tick_q <= tick_q;
                    end
                end
                ST_RESP: begin
                    cmd_ready_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    mem_en_q    <= 1'b0;
                    rd_n_q      <= 1'b1;
                    wr_n_q      <= 1'b1;
                    cmd_ready_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready        = cmd_ready_q;
    assign rsp_valid        = rsp_valid_q;
    assign rsp_rdata        = rsp_rdata_q;
    assign mem_enable_video = mem_en_q;
    assign rd_n_video       = rd_n_q;
    assign wr_n_video       = wr_n_q;
    assign A_video          = a_q;
    assign di_video         = di_q;

endmodule
